// File: rtl/airbag_squib_driver_if.sv
// Deploy-path signal bundle between the airbag controller and the squib driver.
// The controller side (master) drives the request and health inputs; the
// driver side (slave) reports the firing pulse and its sticky status flags.
interface airbag_squib_driver_if;
    logic deploy_req;
    logic arm_en;
    logic squib_ok;
    logic fire;
    logic busy;
    logic deployed;
    logic fault;

    modport master (
        output deploy_req,
        output arm_en,
        output squib_ok,
        input  fire,
        input  busy,
        input  deployed,
        input  fault
    );

    modport slave (
        input  deploy_req,
        input  arm_en,
        input  squib_ok,
        output fire,
        output busy,
        output deployed,
        output fault
    );
endinterface

// File: rtl/airbag_squib_driver.sv
// Squib driver: confirms a deploy request over CONFIRM_CYCLES consecutive
// qualified samples, then issues a single FIRE_CYCLES-wide fire pulse.
// DONE and FAULT are terminal and only a reset leaves them, so the squib can
// never be fired twice without a reset in between.
module airbag_squib_driver #(
    parameter int CONFIRM_CYCLES = 4,
    parameter int FIRE_CYCLES    = 8,
    parameter int CNT_W          = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    airbag_squib_driver_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        CONFIRM,
        FIRE,
        DONE,
        FAULT
    } state_t;

    // The counter only ever reaches CYCLES-1, so these terminal values fit in CNT_W.
    localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0] FIRE_LAST    = CNT_W'(FIRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam bit               CONFIRM_ONE  = (CONFIRM_CYCLES == 1);

    // Reject parameter sets the counter cannot represent.
    if (CONFIRM_CYCLES < 1 || FIRE_CYCLES < 1 ||
        CONFIRM_CYCLES > (2 ** CNT_W) || FIRE_CYCLES > (2 ** CNT_W)) begin : g_bad_params
        $error("airbag_squib_driver: CONFIRM_CYCLES/FIRE_CYCLES must be >= 1 and fit in CNT_W");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qualified;

    assign qualified = bus.deploy_req & bus.arm_en;

    // Next-state and counter logic; FIRE ignores every input once committed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (qualified) begin
                    if (!bus.squib_ok) begin
                        state_d = FAULT;
                    end else if (CONFIRM_ONE) begin
                        state_d = FIRE;
                    end else begin
                        state_d = CONFIRM;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CONFIRM: begin
                if (!qualified) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!bus.squib_ok) begin
                    state_d = FAULT;
                    cnt_d   = '0;
                end else if (cnt_q == CONFIRM_LAST) begin
                    state_d = FIRE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            FIRE: begin
                if (cnt_q == FIRE_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                cnt_d = '0;
            end
            FAULT: begin
                cnt_d = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.fire     = (state_q == FIRE);
    assign bus.busy     = (state_q == CONFIRM) || (state_q == FIRE);
    assign bus.deployed = (state_q == DONE);
    assign bus.fault    = (state_q == FAULT);

endmodule

// File: tb/tb_airbag_squib_driver.sv
// Self-checking bench for airbag_squib_driver: directed scenarios with literal
// expectations plus randomized stimulus, all compared against a behavioural
// model that tracks run length, remaining pulse cycles and sticky flags.
module tb_airbag_squib_driver;

    localparam int CONFIRM_CYCLES = 4;
    localparam int FIRE_CYCLES    = 8;
    localparam int CNT_W          = 8;

    logic clk;
    logic rst_n;
    bit   check_en;

    int total;
    int bad;

    int  run_len;
    int  fire_left;
    bit  m_done;
    bit  m_fault;

    airbag_squib_driver_if bus ();

    airbag_squib_driver #(
        .CONFIRM_CYCLES(CONFIRM_CYCLES),
        .FIRE_CYCLES   (FIRE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: actual=%b expected=%b", name, $time, act, exp);
        end
    endtask

    // Drives one set of inputs, lets one rising edge capture them, then settles.
    task automatic applyStimulus(input logic req, input logic arm, input logic ok, input logic rst);
        bus.deploy_req = req;
        bus.arm_en     = arm;
        bus.squib_ok   = ok;
        rst_n          = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic repeatStimulus(input int n, input logic req, input logic arm, input logic ok);
        for (int i = 0; i < n; i++) applyStimulus(req, arm, ok, 1'b1);
    endtask

    // Behavioural model: counts consecutive healthy qualified samples, then a pulse countdown.
    always @(posedge clk) begin
        if (!rst_n) begin
            run_len   = 0;
            fire_left = 0;
            m_done    = 1'b0;
            m_fault   = 1'b0;
        end else if (m_done || m_fault) begin
            run_len = 0;
        end else if (fire_left > 0) begin
            fire_left = fire_left - 1;
            if (fire_left == 0) m_done = 1'b1;
        end else if (bus.deploy_req && bus.arm_en) begin
            if (!bus.squib_ok) begin
                m_fault = 1'b1;
                run_len = 0;
            end else begin
                run_len = run_len + 1;
                if (run_len == CONFIRM_CYCLES) begin
                    run_len   = 0;
                    fire_left = FIRE_CYCLES;
                end
            end
        end else begin
            run_len = 0;
        end
    end

    // Compares every DUT output against the model once per cycle, away from the edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_fire",     bus.fire,     fire_left > 0);
            checkOutput("model_busy",     bus.busy,     (fire_left > 0) || (run_len > 0));
            checkOutput("model_deployed", bus.deployed, m_done);
            checkOutput("model_fault",    bus.fault,    m_fault);
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        check_en = 1'b0;
        run_len   = 0;
        fire_left = 0;
        m_done    = 1'b0;
        m_fault   = 1'b0;

        // Reset state
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        check_en = 1'b1;
        checkOutput("reset_fire",     bus.fire,     1'b0);
        checkOutput("reset_busy",     bus.busy,     1'b0);
        checkOutput("reset_deployed", bus.deployed, 1'b0);
        checkOutput("reset_fault",    bus.fault,    1'b0);

        // Scenario 1: clean request fires on the 4th edge for 8 cycles
        repeatStimulus(3, 1'b1, 1'b1, 1'b1);
        checkOutput("s1_fire_before", bus.fire, 1'b0);
        checkOutput("s1_busy_confirm", bus.busy, 1'b1);
        repeatStimulus(1, 1'b1, 1'b1, 1'b1);
        checkOutput("s1_fire_4th", bus.fire, 1'b1);
        repeatStimulus(7, 1'b1, 1'b1, 1'b1);
        checkOutput("s1_fire_last", bus.fire, 1'b1);
        repeatStimulus(1, 1'b1, 1'b1, 1'b1);
        checkOutput("s1_fire_end",  bus.fire,     1'b0);
        checkOutput("s1_deployed",  bus.deployed, 1'b1);
        checkOutput("s1_busy_end",  bus.busy,     1'b0);

        // Scenario 6: no second pulse after DONE
        repeatStimulus(1, 1'b0, 1'b1, 1'b1);
        repeatStimulus(10, 1'b1, 1'b1, 1'b1);
        checkOutput("s6_no_refire", bus.fire,     1'b0);
        checkOutput("s6_deployed",  bus.deployed, 1'b1);

        // Scenario 2: glitch burst rejected, second burst fires
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        repeatStimulus(3, 1'b1, 1'b1, 1'b1);
        repeatStimulus(1, 1'b0, 1'b1, 1'b1);
        checkOutput("s2_busy_glitch", bus.busy, 1'b0);
        repeatStimulus(3, 1'b1, 1'b1, 1'b1);
        checkOutput("s2_fire_3rd", bus.fire, 1'b0);
        repeatStimulus(1, 1'b1, 1'b1, 1'b1);
        checkOutput("s2_fire_4th", bus.fire, 1'b1);

        // Scenario 5: reset on the 3rd fire cycle, then fire again
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        repeatStimulus(4, 1'b1, 1'b1, 1'b1);
        repeatStimulus(2, 1'b1, 1'b1, 1'b1);
        checkOutput("s5_fire_3rd", bus.fire, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("s5_rst_fire",     bus.fire,     1'b0);
        checkOutput("s5_rst_deployed", bus.deployed, 1'b0);
        repeatStimulus(4, 1'b1, 1'b1, 1'b1);
        checkOutput("s5_refire", bus.fire, 1'b1);

        // Scenario 3: disarmed request never does anything
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        repeatStimulus(20, 1'b1, 1'b0, 1'b1);
        checkOutput("s3_fire",  bus.fire,  1'b0);
        checkOutput("s3_busy",  bus.busy,  1'b0);
        checkOutput("s3_fault", bus.fault, 1'b0);

        // Scenario 4: continuity loss on the 2nd confirm sample latches fault
        repeatStimulus(1, 1'b1, 1'b1, 1'b1);
        repeatStimulus(1, 1'b1, 1'b1, 1'b0);
        checkOutput("s4_fault", bus.fault, 1'b1);
        repeatStimulus(6, 1'b1, 1'b1, 1'b1);
        checkOutput("s4_fault_sticky", bus.fault, 1'b1);
        checkOutput("s4_no_fire",      bus.fire,  1'b0);

        // Simultaneous drop of request and continuity in CONFIRM: back to idle, no fault
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        repeatStimulus(2, 1'b1, 1'b1, 1'b1);
        repeatStimulus(1, 1'b0, 1'b1, 1'b0);
        checkOutput("sim_fault", bus.fault, 1'b0);
        checkOutput("sim_busy",  bus.busy,  1'b0);

        // Randomized stimulus checked by the model every cycle
        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(0, 9) < 8,
                          $urandom_range(0, 9) < 9,
                          $urandom_range(0, 29) < 29,
                          $urandom_range(0, 39) != 0);
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
